// File: rtl/cdb_round_robin_arbiter.sv
// Common data bus arbiter: N functional-unit result ports compete for one
// broadcast slot per cycle. Round-robin priority starting at ptr; the
// winner is captured in a single registered output stage with valid/ready.
// A mispredict flush kills the held result and blocks grants for that cycle.

module cdb_round_robin_arbiter #(
    parameter int N       = 4,
    parameter int BW_DATA = 32,
    parameter int BW_TAG  = 5,
    localparam int PW     = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         i_ready,
    input  logic [N*BW_DATA-1:0] i_data,
    input  logic [N*BW_TAG-1:0]  i_tag,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [BW_DATA-1:0]   o_data,
    output logic [BW_TAG-1:0]    o_tag,
    output logic [PW-1:0]        o_grant_id
);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      ptr_next;
    logic               any_req;
    logic               load;
    logic [BW_DATA-1:0] data_arr [N];
    logic [BW_TAG-1:0]  tag_arr  [N];

    assign any_req = |i_valid;

    // Output stage can take a new result when empty or being drained,
    // unless a flush is killing the pipeline this cycle.
    assign load = (!o_valid || o_ready) && !i_flush;

    // Unpack the flat per-requester buses so the winner can index them directly.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            data_arr[k] = i_data[k*BW_DATA +: BW_DATA];
            tag_arr[k]  = i_tag[k*BW_TAG +: BW_TAG];
        end
    end

    // Scan ptr, ptr+1, ... wrapping modulo N; first valid requester wins.
    // The modulo is done in int space so non-power-of-two N wraps correctly.
    always_comb begin
        logic          found;
        int            idx_int;
        logic [PW-1:0] idx;
        winner  = '0;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx_int = int'(ptr) + i;
            if (idx_int >= N) begin
                idx_int = idx_int - N;
            end
            idx = PW'(idx_int);
            if (!found && i_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next priority starts just past the winner, wrapping at N-1.
    assign ptr_next = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;

    // One-hot accept to the winner only when the output stage loads.
    always_comb begin
        i_ready = '0;
        if (load && any_req) begin
            i_ready[winner] = 1'b1;
        end
    end

    // Output register and priority pointer. Flush clears valid but leaves the
    // payload fields untouched; stall holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_tag      <= '0;
            o_grant_id <= '0;
            ptr        <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (load) begin
            if (any_req) begin
                o_valid    <= 1'b1;
                o_data     <= data_arr[winner];
                o_tag      <= tag_arr[winner];
                o_grant_id <= winner;
                ptr        <= ptr_next;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_round_robin_arbiter.sv
// Bench for cdb_round_robin_arbiter: directed scenarios followed by a random
// phase. Accepted results are queued at grant time and checked when the CDB
// consumes them; a small reference model tracks priority and output state.

module tb_cdb_round_robin_arbiter;

    localparam int N  = 4;
    localparam int BD = 32;
    localparam int BT = 5;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_ready;
    logic [N*BD-1:0] i_data;
    logic [N*BT-1:0] i_tag;
    logic            i_flush;
    logic            o_valid;
    logic            o_ready;
    logic [BD-1:0]   o_data;
    logic [BT-1:0]   o_tag;
    logic [1:0]      o_grant_id;

    cdb_round_robin_arbiter #(.N(N), .BW_DATA(BD), .BW_TAG(BT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_data     (i_data),
        .i_tag      (i_tag),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_tag      (o_tag),
        .o_grant_id (o_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    gid;
        logic [BT-1:0] tag;
        logic [BD-1:0] data;
    } result_t;

    result_t    sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [N-1:0] last_ready;

    // reference model state
    logic          m_ov;
    logic [BD-1:0] m_od;
    logic [BT-1:0] m_ot;
    logic [1:0]    m_og;
    logic [1:0]    m_ptr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs and i_ready, update
    // scoreboard and model for the coming posedge.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic ordy,
                        input logic fl, input logic force_tag, input logic [BT-1:0] ftag);
        logic [BD-1:0] d [N];
        logic [BT-1:0] t [N];
        logic          found;
        logic [1:0]    w;
        logic          ld;
        logic [N-1:0]  exp_rdy;
        result_t       r;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            d[k] = $urandom;
            t[k] = force_tag ? ftag : BT'($urandom);
            i_data[k*BD +: BD] = d[k];
            i_tag[k*BT +: BT]  = t[k];
        end
        rst_n   = rst;
        i_valid = v;
        o_ready = ordy;
        i_flush = fl;
        #1;
        // registered outputs against model
        chk("o_valid", 64'(o_valid), 64'(m_ov));
        chk("o_tag_hold", 64'(o_tag), 64'(m_ot));
        chk("o_data_hold", 64'(o_data), 64'(m_od));
        chk("o_grant_hold", 64'(o_grant_id), 64'(m_og));
        // expected winner
        found = 1'b0;
        w = 2'd0;
        for (int j = 0; j < N; j++) begin
            if (!found && v[(int'(m_ptr) + j) % N]) begin
                found = 1'b1;
                w = 2'((int'(m_ptr) + j) % N);
            end
        end
        ld = (!m_ov || ordy) && !fl;
        exp_rdy = '0;
        if (ld && found) exp_rdy[w] = 1'b1;
        last_ready = i_ready;
        chk("i_ready", 64'(i_ready), 64'(exp_rdy));
        // scoreboard consume / kill
        if (!rst) begin
            sb_q.delete();
        end else if (o_valid && ordy) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 64'(1), 64'(0));
            end else begin
                r = sb_q.pop_front();
                chk("sb_gid", 64'(o_grant_id), 64'(r.gid));
                chk("sb_tag", 64'(o_tag), 64'(r.tag));
                chk("sb_data", 64'(o_data), 64'(r.data));
            end
        end else if (o_valid && fl) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        // model update
        if (!rst) begin
            m_ov = 1'b0; m_od = '0; m_ot = '0; m_og = '0; m_ptr = '0;
        end else if (fl) begin
            m_ov = 1'b0;
        end else if (ld) begin
            if (found) begin
                m_ov = 1'b1; m_od = d[w]; m_ot = t[w]; m_og = w;
                m_ptr = (w == 2'd3) ? 2'd0 : w + 2'd1;
                r.gid = w; r.tag = t[w]; r.data = d[w];
                sb_q.push_back(r);
            end else begin
                m_ov = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_valid = '0; o_ready = 1'b0; i_flush = 1'b0;
        i_data = '0; i_tag = '0;
        m_ov = 1'b0; m_od = '0; m_ot = '0; m_og = '0; m_ptr = '0;
        // model state is unknown before first reset; first checks are on reset values
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'h0);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 5'h0);
        step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 5'h0);
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_o_tag", 64'(o_tag), 64'(0));

        // full contention: strict 0,1,2,3,0,1,2,3 rotation
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 5'h0);
            chk("rr_order", 64'(last_ready), 64'(4'b0001 << (i % 4)));
            if (i > 0) chk("rr_gid", 64'(o_grant_id), 64'((i - 1) % 4));
        end

        // bring ptr to 2, then wrap-around: index 0 beats 1
        step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 5'h0);
        step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 5'h0);
        step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 5'h0);
        chk("wrap_first", 64'(last_ready), 64'(4'b0001));
        step(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 5'h0);
        chk("wrap_second", 64'(last_ready), 64'(4'b0010));

        // backpressure: ptr=2, capture tag 0x0A from index 2, stall three cycles
        step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 5'h0A);
        chk("bp_grant", 64'(last_ready), 64'(4'b0100));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 5'h0);
            chk("bp_ready", 64'(last_ready), 64'(0));
            chk("bp_tag", 64'(o_tag), 64'(5'h0A));
        end
        step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 5'h0);
        chk("bp_release", 64'(last_ready), 64'(4'b1000));

        // flush while stalled: no grant, valid drops, then index 2 wins
        step(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 5'h0);
        chk("fl_ready", 64'(last_ready), 64'(0));
        step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 5'h0);
        chk("fl_valid", 64'(o_valid), 64'(0));
        chk("fl_regrant", 64'(last_ready), 64'(4'b0100));

        // idle drains the output stage and leaves ptr at 3
        step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 5'h0);
        step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 5'h0);
        chk("idle_valid", 64'(o_valid), 64'(0));
        chk("idle_ptr", 64'(last_ready), 64'(4'b1000));

        // reset with a held result: valid cleared, ptr back to 0
        step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 5'h0);
        step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 5'h0);
        step(1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 5'h0);
        chk("rst_mid_valid", 64'(o_valid), 64'(0));
        chk("rst_mid_ptr", 64'(last_ready), 64'(4'b0001));

        // random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), 1'b0, 5'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
